alu_ctrl: RTL and testbench
===========================

// Module: alu_ctrl
// PURPOSE
//  Initiator side of the ALU interface. It accepts commands over a valid/ready handshake and
//  reads operands from an internal register file. For ALU ops it issues a one-cycle enable
//  pulse and captures the registered result one cycle later. It then writes back the result,
//  latches the zero/carry flags and pulses a response. It sits between the instruction
//  source and the ALU.
// PARAMETERS
//  N      8                      datapath width; must equal the ALU's N
//  NREG   4                      register-file entries; power of 2, >= 2
//  RAW    $clog2(NREG)           register index width (derived; do not override)
// PORTS
//  clk            in   1     single clock; all state on posedge
//  rst            in   1     asynchronous, active-high reset
//  cmd_valid      in   1     command present
//  cmd_ready      out  1     controller can accept (high only in IDLE)
//  cmd_op         in   2     CMD_NOP / CMD_LDI / CMD_MOV / CMD_ALU
//  cmd_mode       in   N     ALU mode (`OP_ADD/SUB/AND/OR/XOR), used by CMD_ALU only
//  cmd_rd         in   RAW   destination register
//  cmd_ra         in   RAW   source A (CMD_MOV source, ALU in_a)
//  cmd_rb         in   RAW   source B (ALU in_b)
//  cmd_imm        in   N     immediate for CMD_LDI
//  rsp_valid      out  1     one-cycle completion pulse
//  rsp_data       out  N     value written to rd (0 for NOP)
//  rsp_zero       out  1     zero flag register
//  rsp_carry      out  1     carry flag register
//  alu_enable     out  1     ALU enable
//  alu_mode       out  N     ALU mode
//  alu_a, alu_b   out  N     ALU operands
//  alu_out        in   N     ALU registered result
//  alu_zero       in   1     ALU zero flag (combinational from alu_out)
//  alu_carry      in   1     ALU carry flag (registered; updated only by ADD/SUB)
// BEHAVIOUR
//  - Reset: state=IDLE; all regfile entries, flags, rsp_*, alu_enable, alu_mode, alu_a and
//    alu_b are 0. cmd_ready=1 as soon as rst deasserts.
//  - FSM: IDLE -> (accept CMD_ALU) ISSUE -> WB -> IDLE. Accept = cmd_valid & cmd_ready.
//  - On accepting CMD_ALU at edge E0:
//    - latch regfile[ra], regfile[rb], mode and rd into alu_a, alu_b, alu_mode and a held rd.
//    - go to ISSUE.
//  - ISSUE: alu_enable=1 for exactly this cycle. The ALU captures the result at edge E1.
//  - WB: alu_enable=0. At edge E2:
//    - regfile[rd] <= alu_out; zero flag <= alu_zero.
//    - carry flag <= alu_carry only if the mode is `OP_ADD/`OP_SUB; otherwise carry is held.
//    - rsp_valid=1 and rsp_data=alu_out for the cycle after E2; go to IDLE.
//  - ALU command latency: rsp_valid is high 3 cycles after the accept edge. Throughput is one
//    ALU command per 3 cycles.
//  - Other ops complete at the accept edge and stay in IDLE. rsp_valid is high the next cycle.
//    They never touch the flags or alu_enable.
//    - CMD_LDI: regfile[rd] <= imm.
//    - CMD_MOV: regfile[rd] <= regfile[ra].
//    - CMD_NOP: no write; rsp_data = 0.
//  - Back-to-back commands: a command may be accepted in the same cycle rsp_valid is high.
//    A write at edge Ek is visible to a command accepted at edge Ek+1.
//  - Unrecognised cmd_mode is forwarded unchanged. The ALU yields 0, so rsp_data=0 and zero=1;
//    carry is held.
//  - cmd_* are ignored while cmd_ready=0. A source holding cmd_valid is accepted on the
//    first IDLE cycle; no command is dropped or duplicated.
//  - alu_out/alu_zero are sampled only in WB. Post-reset ALU contents, which are not reset,
//    are never observed.
//  - rd == ra/rb is legal because operands are latched at accept.
//  - Reset mid-operation (ISSUE or WB): asynchronous return to IDLE; alu_enable drops
//    immediately; no writeback; no rsp_valid.
// STRUCTURE
//  - Shared package: CMD_NOP=2'b00, CMD_LDI=2'b01, CMD_MOV=2'b10, CMD_ALU=2'b11 and the
//    FSM state enum {IDLE, ISSUE, WB}.
//  - ALU mode codes stay in rtl/parameters.sv.
//  - Sub-module ctrl_regfile: NREG x N, one write port, two async read ports, async-reset
//    to 0.
// TESTING
//  1 Reset: pulse rst mid-clock -> all outputs 0 immediately; cmd_ready=1 at the first clk
//    after release.
//  2 LDI r0=0xF0, LDI r1=0x20, ALU ADD r2=r0+r1:
//    -> alu_enable high exactly 1 cycle with a=0xF0, b=0x20.
//    -> rsp_valid 3 cycles after accept with data=0x10, carry=1, zero=0; regfile r2=0x10.
//  3 ALU SUB r3=r1-r1 -> data=0x00, zero=1, carry=0. Then LDI r0=0xFF and ALU ADD r2=r0+r1
//    (0xFF+0x20) -> carry=1. Then ALU AND r0=r0&r1 -> data=0x20, zero=0, carry stays 1.
//  4 cmd_valid held high with 2 queued ALU cmds:
//    -> cmd_ready low during ISSUE/WB; second accepted on the IDLE cycle after the first
//       WB; exactly 2 rsp pulses.
//  5 rst asserted during ISSUE -> alu_enable 0 without a clock; no rsp_valid; r0..r3 read 0.
//  6 MOV r3<-r2 (r2=0x10) -> rsp_data=0x10 next cycle, flags unchanged. ALU with mode 0xEE
//    -> data=0x00, zero=1, carry held.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// alu_ctrl_pkg : command codes, FSM states and ALU mode constants for alu_ctrl
// Revision     : 1.0
// ============================================================================
`include "parameters.sv"
`default_nettype none

package alu_ctrl_pkg;

   localparam logic [1:0] CMD_NOP = 2'b00;
   localparam logic [1:0] CMD_LDI = 2'b01;
   localparam logic [1:0] CMD_MOV = 2'b10;
   localparam logic [1:0] CMD_ALU = 2'b11;

   localparam int MODE_ADD = `OP_ADD;
   localparam int MODE_SUB = `OP_SUB;
   localparam int MODE_AND = `OP_AND;
   localparam int MODE_OR  = `OP_OR;
   localparam int MODE_XOR = `OP_XOR;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WB    = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_ctrl_regfile.sv
// ============================================================================
// ctrl_regfile : NREG x N register file, one write port, two async read ports
// Revision     : 1.0
// ============================================================================
`default_nettype none

module ctrl_regfile #(
   parameter int N    = 8,
   parameter int NREG = 4,
   parameter int RAW  = $clog2(NREG)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           i_we,
   input  logic [RAW-1:0] i_waddr,
   input  logic [N-1:0]   i_wdata,
   input  logic [RAW-1:0] i_raddr_a,
   output logic [N-1:0]   o_rdata_a,
   input  logic [RAW-1:0] i_raddr_b,
   output logic [N-1:0]   o_rdata_b
);

   logic [N-1:0] r_mem [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/parameters.sv
// ============================================================================
// parameters.sv : ALU mode codes shared by the ALU and its controller
// Revision      : 1.0
// ============================================================================
`ifndef ALU_PARAMETERS_SV
`define ALU_PARAMETERS_SV
`default_nettype none

`define OP_ADD 1
`define OP_SUB 2
`define OP_AND 3
`define OP_OR  4
`define OP_XOR 5

`default_nettype wire
`endif

// File: rtl/alu_ctrl.sv
// ============================================================================
// alu_ctrl : command-driven initiator for a registered ALU with a local regfile
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int N    = 8,
   parameter int NREG = 4,
   parameter int RAW  = $clog2(NREG)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [1:0]     cmd_op,
   input  logic [N-1:0]   cmd_mode,
   input  logic [RAW-1:0] cmd_rd,
   input  logic [RAW-1:0] cmd_ra,
   input  logic [RAW-1:0] cmd_rb,
   input  logic [N-1:0]   cmd_imm,
   output logic           rsp_valid,
   output logic [N-1:0]   rsp_data,
   output logic           rsp_zero,
   output logic           rsp_carry,
   output logic           alu_enable,
   output logic [N-1:0]   alu_mode,
   output logic [N-1:0]   alu_a,
   output logic [N-1:0]   alu_b,
   input  logic [N-1:0]   alu_out,
   input  logic           alu_zero,
   input  logic           alu_carry
);

   state_t         r_state;
   logic [RAW-1:0] r_rd;
   logic           r_zero;
   logic           r_carry;

   logic           w_accept;
   logic           w_we;
   logic [RAW-1:0] w_waddr;
   logic [N-1:0]   w_wdata;
   logic [N-1:0]   w_rdata_a;
   logic [N-1:0]   w_rdata_b;
   logic           w_sets_carry;

   // Held low during reset so no command can be seen as accepted mid-reset.
   assign cmd_ready    = (r_state == IDLE) & ~rst;
   assign w_accept     = cmd_valid & cmd_ready;
   assign w_sets_carry = (alu_mode == N'(MODE_ADD)) | (alu_mode == N'(MODE_SUB));
   assign rsp_zero     = r_zero;
   assign rsp_carry    = r_carry;

   // WB owns the write port; IDLE ops can never collide since accept needs IDLE.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = cmd_rd;
      w_wdata = cmd_imm;
      if (r_state == WB) begin
         w_we    = 1'b1;
         w_waddr = r_rd;
         w_wdata = alu_out;
      end else if (w_accept) begin
         case (cmd_op)
            CMD_LDI: w_we = 1'b1;
            CMD_MOV: begin
               w_we    = 1'b1;
               w_wdata = w_rdata_a;
            end
            default: w_we = 1'b0;
         endcase
      end
   end

   ctrl_regfile #(
      .N    (N),
      .NREG (NREG),
      .RAW  (RAW)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (cmd_ra),
      .o_rdata_a (w_rdata_a),
      .i_raddr_b (cmd_rb),
      .o_rdata_b (w_rdata_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_rd       <= '0;
         r_zero     <= 1'b0;
         r_carry    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         alu_enable <= 1'b0;
         alu_mode   <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
      end else begin
         rsp_valid  <= 1'b0;
         alu_enable <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (cmd_op == CMD_ALU) begin
                     alu_a      <= w_rdata_a;
                     alu_b      <= w_rdata_b;
                     alu_mode   <= cmd_mode;
                     r_rd       <= cmd_rd;
                     alu_enable <= 1'b1;
                     r_state    <= ISSUE;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= (cmd_op == CMD_NOP) ? '0 : w_wdata;
                  end
               end
            end
            ISSUE: begin
               r_state <= WB;
            end
            WB: begin
               rsp_valid <= 1'b1;
               rsp_data  <= alu_out;
               r_zero    <= alu_zero;
               if (w_sets_carry) begin
                  r_carry <= alu_carry;
               end
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl.sv
// ============================================================================
// tb_alu_ctrl : self-checking bench for alu_ctrl with a behavioural ALU attached
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_ctrl;
   import alu_ctrl_pkg::*;

   localparam int NREG = 4;
   localparam logic [7:0] M_ADD = 8'(MODE_ADD);
   localparam logic [7:0] M_SUB = 8'(MODE_SUB);
   localparam logic [7:0] M_AND = 8'(MODE_AND);
   localparam logic [7:0] M_OR  = 8'(MODE_OR);
   localparam logic [7:0] M_XOR = 8'(MODE_XOR);

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_mode = 8'h00;
   logic [1:0] cmd_rd = 2'b00;
   logic [1:0] cmd_ra = 2'b00;
   logic [1:0] cmd_rb = 2'b00;
   logic [7:0] cmd_imm = 8'h00;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_zero;
   logic       rsp_carry;
   logic       alu_enable;
   logic [7:0] alu_mode;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [7:0] alu_out = 8'h00;
   logic       alu_zero;
   logic       alu_carry = 1'b0;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_ctrl #(.N(8), .NREG(NREG)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
      .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
      .alu_enable(alu_enable), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry)
   );

   // ALU behaviour: {carry/borrow, result}; unknown modes yield 0
   function automatic logic [8:0] alu_fn(input logic [7:0] m, input logic [7:0] a, input logic [7:0] b);
      case (int'(m))
         MODE_ADD: return {1'b0, a} + {1'b0, b};
         MODE_SUB: return {1'b0, a} - {1'b0, b};
         MODE_AND: return {1'b0, a & b};
         MODE_OR:  return {1'b0, a | b};
         MODE_XOR: return {1'b0, a ^ b};
         default:  return 9'd0;
      endcase
   endfunction

   function automatic bit is_arith(input logic [7:0] m);
      return (int'(m) == MODE_ADD) || (int'(m) == MODE_SUB);
   endfunction

   logic [8:0] w_alu;
   assign w_alu    = alu_fn(alu_mode, alu_a, alu_b);
   assign alu_zero = (alu_out == 8'h00);

   always @(posedge clk) begin
      if (alu_enable) begin
         alu_out <= w_alu[7:0];
         if (is_arith(alu_mode)) alu_carry <= w_alu[8];
      end
   end

   // Reference model of the controller's architectural state
   logic [7:0] m_reg [NREG];
   logic       m_z;
   logic       m_c;

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_reg[i] = 8'h00;
      m_z = 1'b0;
      m_c = 1'b0;
   endtask

   task automatic model_exec(input logic [1:0] op, input logic [7:0] mode, input int rd,
                             input int ra, input int rb, input logic [7:0] imm,
                             output logic [7:0] d);
      logic [8:0] r;
      d = 8'h00;
      case (op)
         CMD_LDI: begin d = imm; m_reg[rd] = imm; end
         CMD_MOV: begin d = m_reg[ra]; m_reg[rd] = d; end
         CMD_ALU: begin
            r = alu_fn(mode, m_reg[ra], m_reg[rb]);
            d = r[7:0];
            m_reg[rd] = d;
            m_z = (d == 8'h00);
            if (is_arith(mode)) m_c = r[8];
         end
         default: d = 8'h00;
      endcase
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] op;
      logic [7:0] mode;
      int         rd;
      int         ra;
      int         rb;
      logic [7:0] imm;
      logic [7:0] d;
      logic       z;
      logic       c;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] op, input logic [7:0] mode, input int rd,
                               input int ra, input int rb, input logic [7:0] imm,
                               input logic [7:0] d, input logic z, input logic c);
      vec_t v;
      v.op = op; v.mode = mode; v.rd = rd; v.ra = ra; v.rb = rb;
      v.imm = imm; v.d = d; v.z = z; v.c = c;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      cmd_op   = v.op;
      cmd_mode = v.mode;
      cmd_rd   = 2'(v.rd);
      cmd_ra   = 2'(v.ra);
      cmd_rb   = 2'(v.rb);
      cmd_imm  = v.imm;
   endtask

   // One command end to end; expectations from the vector or from the model
   task automatic run_cmd(input vec_t v, input bit use_model);
      logic [7:0] ea, eb, md;
      int lat, g;
      ea = m_reg[v.ra];
      eb = m_reg[v.rb];
      model_exec(v.op, v.mode, v.rd, v.ra, v.rb, v.imm, md);
      if (use_model) begin
         v.d = md; v.z = m_z; v.c = m_c;
      end
      @(negedge clk);
      drive(v);
      cmd_valid = 1'b1;
      g = 0;
      while (!cmd_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("ready_wait", 32'(g < 20), 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_imm   = 8'($urandom);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (v.op == CMD_ALU && lat == 1) begin
            chk("alu_en_issue", 32'(alu_enable), 32'd1);
            chk("alu_a", 32'(alu_a), 32'(ea));
            chk("alu_b", 32'(alu_b), 32'(eb));
         end
         if (v.op == CMD_ALU && lat == 2) chk("alu_en_wb", 32'(alu_enable), 32'd0);
         if (v.op != CMD_ALU && lat == 1) chk("alu_en_idle", 32'(alu_enable), 32'd0);
      end while (!rsp_valid && lat < 8);
      chk("latency", 32'(lat), (v.op == CMD_ALU) ? 32'd3 : 32'd1);
      chk("rsp_data", 32'(rsp_data), 32'(v.d));
      chk("rsp_zero", 32'(rsp_zero), 32'(v.z));
      chk("rsp_carry", 32'(rsp_carry), 32'(v.c));
      @(negedge clk);
      chk("rsp_pulse", 32'(rsp_valid), 32'd0);
   endtask

   vec_t vecs[$];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q_d[$];
      logic [7:0] md;
      vec_t va, vb, vr;
      int nacc, acc0, acc1, pulses, rv, sel;
      bit acc;

      // Reset asserted between clock edges
      model_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_flags", 32'({rsp_valid, rsp_zero, rsp_carry, alu_enable}), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
      chk("rst_alu_ops", 32'({alu_a, alu_b, alu_mode}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_rst", 32'(cmd_ready), 32'd1);

      vecs.push_back(mk(CMD_LDI, 8'h00, 0, 0, 0, 8'hF0, 8'hF0, 1'b0, 1'b0));
      vecs.push_back(mk(CMD_LDI, 8'h00, 1, 0, 0, 8'h20, 8'h20, 1'b0, 1'b0));
      vecs.push_back(mk(CMD_ALU, M_ADD, 2, 0, 1, 8'h00, 8'h10, 1'b0, 1'b1));
      vecs.push_back(mk(CMD_ALU, M_SUB, 3, 1, 1, 8'h00, 8'h00, 1'b1, 1'b0));
      vecs.push_back(mk(CMD_LDI, 8'h00, 0, 0, 0, 8'hFF, 8'hFF, 1'b1, 1'b0));
      vecs.push_back(mk(CMD_ALU, M_ADD, 2, 0, 1, 8'h00, 8'h1F, 1'b0, 1'b1));
      vecs.push_back(mk(CMD_ALU, M_AND, 0, 0, 1, 8'h00, 8'h20, 1'b0, 1'b1));
      vecs.push_back(mk(CMD_LDI, 8'h00, 2, 0, 0, 8'h10, 8'h10, 1'b0, 1'b1));
      vecs.push_back(mk(CMD_MOV, 8'h00, 3, 2, 0, 8'h55, 8'h10, 1'b0, 1'b1));
      vecs.push_back(mk(CMD_ALU, 8'hEE, 3, 1, 1, 8'h00, 8'h00, 1'b1, 1'b1));
      vecs.push_back(mk(CMD_NOP, 8'h00, 1, 0, 0, 8'hAA, 8'h00, 1'b1, 1'b1));
      vecs.push_back(mk(CMD_LDI, 8'h00, 1, 0, 0, 8'h0F, 8'h0F, 1'b1, 1'b1));
      vecs.push_back(mk(CMD_ALU, M_XOR, 2, 0, 1, 8'h00, 8'h2F, 1'b0, 1'b1));
      vecs.push_back(mk(CMD_ALU, M_OR,  1, 1, 0, 8'h00, 8'h2F, 1'b0, 1'b1));
      vecs.push_back(mk(CMD_ALU, M_SUB, 3, 0, 1, 8'h00, 8'hF1, 1'b0, 1'b1));
      vecs.push_back(mk(CMD_ALU, M_SUB, 0, 1, 0, 8'h00, 8'h0F, 1'b0, 1'b0));
      for (int i = 0; i < vecs.size(); i++) run_cmd(vecs[i], 1'b0);

      // Two ALU commands queued behind a continuously asserted cmd_valid
      va = mk(CMD_ALU, M_ADD, 2, 0, 1, 8'h00, 8'h00, 1'b0, 1'b0);
      vb = mk(CMD_ALU, M_XOR, 3, 2, 0, 8'h00, 8'h00, 1'b0, 1'b0);
      nacc = 0; acc0 = 0; acc1 = 0; pulses = 0;
      @(negedge clk);
      drive(va);
      cmd_valid = 1'b1;
      for (int n = 0; n < 14; n++) begin
         if (rsp_valid) begin
            pulses++;
            if (q_d.size() > 0) chk("queued_data", 32'(rsp_data), 32'(q_d.pop_front()));
         end
         if (nacc == 1 && (n == acc0 + 1 || n == acc0 + 2)) chk("ready_low_busy", 32'(cmd_ready), 32'd0);
         acc = cmd_valid && cmd_ready;
         if (acc) begin
            if (nacc == 0) begin
               model_exec(va.op, va.mode, va.rd, va.ra, va.rb, va.imm, md);
               acc0 = n;
            end else begin
               model_exec(vb.op, vb.mode, vb.rd, vb.ra, vb.rb, vb.imm, md);
               acc1 = n;
            end
            q_d.push_back(md);
            nacc++;
         end
         @(posedge clk);
         #1;
         if (acc) begin
            if (nacc == 1) drive(vb);
            else cmd_valid = 1'b0;
         end
         @(negedge clk);
      end
      chk("queued_accepts", 32'(nacc), 32'd2);
      chk("queued_gap", 32'(acc1 - acc0), 32'd3);
      chk("queued_pulses", 32'(pulses), 32'd2);

      // Reset while the ALU command is in ISSUE
      @(negedge clk);
      drive(mk(CMD_ALU, M_ADD, 2, 0, 1, 8'h00, 8'h00, 1'b0, 1'b0));
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("issue_enable", 32'(alu_enable), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_drops_enable", 32'(alu_enable), 32'd0);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rv = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid) rv++;
      end
      chk("no_rsp_after_rst", 32'(rv), 32'd0);
      model_reset();
      for (int i = 0; i < NREG; i++) run_cmd(mk(CMD_MOV, 8'h00, i, i, 0, 8'h00, 8'h00, 1'b0, 1'b0), 1'b1);

      // Randomised commands against the model
      for (int k = 0; k < 60; k++) begin
         vr.op  = 2'($urandom_range(0, 3));
         sel    = $urandom_range(0, 6);
         vr.mode = (sel <= 4) ? 8'(MODE_ADD + sel) : 8'($urandom);
         vr.rd  = $urandom_range(0, NREG - 1);
         vr.ra  = $urandom_range(0, NREG - 1);
         vr.rb  = $urandom_range(0, NREG - 1);
         vr.imm = 8'($urandom);
         vr.d = 8'h00; vr.z = 1'b0; vr.c = 1'b0;
         run_cmd(vr, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
